acc_ctrl: RTL and testbench

Accumulation controller that drives the `acc_match_i` input of the accumulating PEs in the PEA. It counts valid operand beats and pulses a per-PE match at the first beat of every accumulation window, then issues one trailing flush match after the final window. It also tracks vector-mode output latency, so it can flag when each accumulated result lands on the PE outputs and when the whole job is complete.

---
 rtl/acc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_acc_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl.sv
// Accumulation controller: pulses a per-PE acc_match at the first beat of every window plus a
// trailing flush, then tracks vector-mode output latency to flag landed results and job end.
module acc_ctrl #(
    parameter int N_PE      = 16,
    parameter int CNT_W     = 16,
    parameter int FLUSH_DLY = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] acc_len_i,
    input  logic [CNT_W-1:0] n_acc_i,
    input  logic [1:0]       vec_mode_i,
    input  logic [N_PE-1:0]  pe_en_i,
    input  logic             stream_valid_i,
    output logic [N_PE-1:0]  acc_match_o,
    output logic             res_valid_o,
    output logic [CNT_W-1:0] res_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int DLY_W = (FLUSH_DLY > 2) ? $clog2(FLUSH_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((FLUSH_DLY > 0) ? FLUSH_DLY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH_WAIT,
        FLUSH,
        DRAIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] n_q;
    logic [1:0]       mode_q;
    logic [N_PE-1:0]  mask_q;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] wc;
    logic [DLY_W-1:0] dly_cnt;
    logic [3:0]       pipe;
    logic [CNT_W-1:0] res_idx;
    logic             done_q;

    logic run_beat;
    logic run_match;
    logic flush_match;
    logic closing;
    logic last_beat;
    logic res_bit;
    logic pend;

    assign run_beat    = (state == RUN) && stream_valid_i;
    assign run_match   = run_beat && (bc == '0);
    assign flush_match = (state == FLUSH);
    // The very first match of a job opens window 0; every later one closes a window.
    assign closing     = (run_match && (wc != '0)) || flush_match;
    assign last_beat   = run_beat && (wc == n_q - CNT_W'(1)) && (bc == len_q - CNT_W'(1));

    // Tap the token line at the mode's latency; pend means a token is still short of the tap.
    always_comb begin
        res_bit = pipe[0];
        pend    = 1'b0;
        case (mode_q)
            2'b01: begin
                res_bit = pipe[3];
                pend    = |pipe[2:0];
            end
            2'b10: begin
                res_bit = pipe[2];
                pend    = |pipe[1:0];
            end
            default: begin
                res_bit = pipe[0];
                pend    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            len_q   <= '0;
            n_q     <= '0;
            mode_q  <= '0;
            mask_q  <= '0;
            bc      <= '0;
            wc      <= '0;
            dly_cnt <= '0;
            pipe    <= '0;
            res_idx <= '0;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state   <= IDLE;
            bc      <= '0;
            wc      <= '0;
            dly_cnt <= '0;
            pipe    <= '0;
            res_idx <= '0;
            done_q  <= 1'b0;
        end else begin
            pipe   <= {pipe[2:0], closing};
            done_q <= 1'b0;
            if (res_bit) begin
                res_idx <= res_idx + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q   <= (acc_len_i == '0) ? CNT_W'(1) : acc_len_i;
                        n_q     <= n_acc_i;
                        mode_q  <= vec_mode_i;
                        mask_q  <= pe_en_i;
                        bc      <= '0;
                        wc      <= '0;
                        pipe    <= '0;
                        res_idx <= '0;
                        state   <= (n_acc_i == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (run_beat) begin
                        if (last_beat) begin
                            bc      <= '0;
                            dly_cnt <= '0;
                            state   <= (FLUSH_DLY == 0) ? FLUSH : FLUSH_WAIT;
                        end else if (bc == len_q - CNT_W'(1)) begin
                            bc <= '0;
                            wc <= wc + CNT_W'(1);
                        end else begin
                            bc <= bc + CNT_W'(1);
                        end
                    end
                end
                FLUSH_WAIT: begin
                    if (dly_cnt == DLY_LAST) begin
                        state <= FLUSH;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end
                FLUSH: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    // done lands the cycle after the last token reaches the tap; leave DRAIN after it.
                    if (done_q) begin
                        state <= IDLE;
                    end else if (!pend) begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign acc_match_o = (run_match || flush_match) ? mask_q : '0;
    assign res_valid_o = res_bit;
    assign res_idx_o   = res_idx;
    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: an event-level model predicts match, result, busy and done
// timelines per job from the window rules; directed scenarios cover abort, collisions and reset.
module tb_acc_ctrl;

    localparam int N_PE      = 16;
    localparam int CNT_W     = 16;
    localparam int FLUSH_DLY = 1;
    localparam int MAXC      = 300;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic             clear    = 1'b0;
    logic [CNT_W-1:0] acc_len  = '0;
    logic [CNT_W-1:0] n_acc    = '0;
    logic [1:0]       mode     = '0;
    logic [N_PE-1:0]  pe_en    = '0;
    logic             valid    = 1'b0;
    logic [N_PE-1:0]  acc_match;
    logic             res_valid;
    logic [CNT_W-1:0] res_idx;
    logic             busy;
    logic             done;

    int n_cmp  = 0;
    int n_fail = 0;

    bit               vld       [MAXC];
    logic [N_PE-1:0]  exp_match [MAXC];
    logic             exp_rv    [MAXC];
    logic [CNT_W-1:0] exp_idx   [MAXC];
    logic             exp_done  [MAXC];
    logic             exp_busy  [MAXC];

    acc_ctrl #(
        .N_PE     (N_PE),
        .CNT_W    (CNT_W),
        .FLUSH_DLY(FLUSH_DLY)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .clear_i       (clear),
        .acc_len_i     (acc_len),
        .n_acc_i       (n_acc),
        .vec_mode_i    (mode),
        .pe_en_i       (pe_en),
        .stream_valid_i(valid),
        .acc_match_o   (acc_match),
        .res_valid_o   (res_valid),
        .res_idx_o     (res_idx),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    function automatic int latency_of(input logic [1:0] m);
        case (m)
            2'b01:   return 4;
            2'b10:   return 3;
            default: return 1;
        endcase
    endfunction

    // Timeline of one job, cycle 0 being the start cycle: beats are the valid cycles in order,
    // windows start every L beats, the flush follows the last beat, results trail closings by D.
    task automatic build_model(input int len, input int num, input logic [1:0] m,
                               input logic [N_PE-1:0] mask, output int done_cyc);
        int leff;
        int total;
        int beat;
        int last;
        int lat;
        int closes[$];
        for (int c = 0; c < MAXC; c++) begin
            exp_match[c] = '0;
            exp_rv[c]    = 1'b0;
            exp_idx[c]   = '0;
            exp_done[c]  = 1'b0;
            exp_busy[c]  = 1'b0;
        end
        if (num == 0) begin
            done_cyc = 2;
        end else begin
            leff  = (len == 0) ? 1 : len;
            total = leff * num;
            beat  = 0;
            last  = 0;
            lat   = latency_of(m);
            for (int c = 1; c < MAXC && beat < total; c++) begin
                if (vld[c]) begin
                    if (beat % leff == 0) begin
                        exp_match[c] = mask;
                        if (beat != 0) closes.push_back(c);
                    end
                    last = c;
                    beat++;
                end
            end
            exp_match[last + 1 + FLUSH_DLY] = mask;
            closes.push_back(last + 1 + FLUSH_DLY);
            foreach (closes[i]) begin
                exp_rv[closes[i] + lat]  = 1'b1;
                exp_idx[closes[i] + lat] = CNT_W'(i);
            end
            done_cyc = closes[closes.size() - 1] + lat + 1;
        end
        exp_done[done_cyc] = 1'b1;
        for (int c = 1; c <= done_cyc; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({acc_match, res_valid, res_idx, busy, done} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got match=%h rv=%b idx=%0d busy=%b done=%b, want all 0",
                     acc_match, res_valid, res_idx, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_empty_job();
        @(negedge clk);
        start   = 1'b1;
        n_acc   = '0;
        acc_len = 16'd3;
        mode    = 2'b00;
        pe_en   = 16'hFFFF;
        valid   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            logic [N_PE+1:0] want;
            @(negedge clk);
            start = 1'b0;
            #1;
            want = {16'h0, (c <= 2), (c == 2)};
            n_cmp++;
            if ({acc_match, busy, done} !== want) begin
                n_fail++;
                $display("[TB] FAIL empty_job c%0d: got match=%h busy=%b done=%b, want match=%h busy=%b done=%b",
                         c, acc_match, busy, done, want[N_PE+1:2], want[1], want[0]);
            end
        end
        valid = 1'b0;
    endtask

    // Directed jobs first, then randomized ones; even-numbered random jobs start in the very
    // first IDLE cycle after done, and random jobs wiggle start/config inputs while busy.
    task automatic test_model_jobs();
        for (int j = 0; j < 24; j++) begin
            int len;
            int num;
            int pat;
            int done_cyc;
            int trail;
            bit noisy;
            logic [1:0] m;
            logic [N_PE-1:0] mask;
            noisy = 1'b0;
            pat   = 0;
            case (j)
                0: begin len = 4; num = 3; m = 2'b00; mask = 16'h0001; end
                1: begin len = 3; num = 2; m = 2'b01; mask = 16'h0F0F; pat = 1; end
                2: begin len = 0; num = 2; m = 2'b10; mask = 16'hFFFF; end
                3: begin len = 5; num = 0; m = 2'b00; mask = 16'h1234; end
                default: begin
                    len   = $urandom_range(0, 5);
                    num   = $urandom_range(0, 4);
                    m     = 2'($urandom_range(0, 2));
                    mask  = 16'($urandom);
                    pat   = 2;
                    noisy = 1'b1;
                end
            endcase
            for (int c = 0; c < MAXC; c++) begin
                case (pat)
                    0:       vld[c] = 1'b1;
                    1:       vld[c] = (c % 2 == 1);
                    default: vld[c] = (c > 100) || ($urandom_range(0, 99) < 60);
                endcase
            end
            build_model(len, num, m, mask, done_cyc);
            trail = (j >= 4 && j % 2 == 0) ? 0 : 2;
            @(negedge clk);
            start   = 1'b1;
            acc_len = CNT_W'(len);
            n_acc   = CNT_W'(num);
            mode    = m;
            pe_en   = mask;
            valid   = 1'b0;
            for (int c = 1; c <= done_cyc + trail; c++) begin
                logic [N_PE+CNT_W+2:0] want;
                logic [N_PE+CNT_W+2:0] got;
                @(negedge clk);
                start = noisy && (c <= done_cyc) && ($urandom_range(0, 7) == 0);
                if (noisy) begin
                    acc_len = 16'($urandom);
                    n_acc   = 16'($urandom);
                    mode    = 2'($urandom);
                    pe_en   = 16'($urandom);
                end
                valid = vld[c];
                #1;
                want = {exp_match[c], exp_rv[c], exp_idx[c], exp_done[c], exp_busy[c]};
                got  = {acc_match, res_valid, exp_rv[c] ? res_idx : 16'h0, done, busy};
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("[TB] FAIL job%0d c%0d {match,rv,idx,done,busy}: got %h, want %h (L=%0d N=%0d mode=%0d)",
                             j, c, got, want, len, num, m);
                end
            end
            start = 1'b0;
        end
        valid = 1'b0;
    endtask

    task automatic test_abort();
        logic [N_PE-1:0] mask;
        mask = 16'($urandom) | 16'h0001;
        @(negedge clk);
        start   = 1'b1;
        acc_len = 16'd4;
        n_acc   = 16'd3;
        mode    = 2'b01;
        pe_en   = mask;
        valid   = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            clear = (c == 6);
            valid = 1'b1;
            #1;
            if (c == 5) begin
                n_cmp++;
                if (acc_match !== mask) begin
                    n_fail++;
                    $display("[TB] FAIL abort_window1_match: got %h, want %h", acc_match, mask);
                end
            end
            if (c >= 7) begin
                n_cmp++;
                if ({acc_match, res_valid, res_idx, busy, done} !== '0) begin
                    n_fail++;
                    $display("[TB] FAIL abort_idle c%0d: got match=%h rv=%b idx=%0d busy=%b done=%b, want all 0",
                             c, acc_match, res_valid, res_idx, busy, done);
                end
            end
        end
        clear = 1'b0;
        valid = 1'b0;
    endtask

    task automatic test_start_collision();
        @(negedge clk);
        start   = 1'b1;
        clear   = 1'b1;
        acc_len = 16'd2;
        n_acc   = 16'd2;
        mode    = 2'b00;
        pe_en   = 16'hFFFF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            clear = 1'b0;
            valid = 1'b1;
            #1;
            n_cmp++;
            if ({acc_match, busy, done} !== '0) begin
                n_fail++;
                $display("[TB] FAIL start_clear_collision c%0d: got match=%h busy=%b done=%b, want 0 0 0",
                         c, acc_match, busy, done);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start   = 1'b1;
        acc_len = 16'd1;
        n_acc   = 16'd6;
        mode    = 2'b00;
        pe_en   = 16'h00FF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            valid = 1'b1;
        end
        #1;
        n_cmp++;
        if (busy !== 1'b1 || res_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL async_reset_prejob: got busy=%b rv=%b, want 1 1", busy, res_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({acc_match, res_valid, res_idx, busy, done} !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset_midjob: got match=%h rv=%b idx=%0d busy=%b done=%b, want all 0",
                     acc_match, res_valid, res_idx, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_empty_job();
        test_model_jobs();
        test_abort();
        test_start_collision();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
